imem_pipelined: RTL and testbench

//  Parametrised instruction memory for the RV32 fetch stage. Byte-addressed, little-endian, word-organised.

---
 rtl/imem_pkg.sv | 30 +++
 rtl/imem_rsp_fifo.sv | 57 +++++
 rtl/imem_pipelined.sv | 113 +++++++++++
 tb/tb_imem_pipelined.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types for the fetch-stage instruction memory: fault codes, FSM states
// and the response record carried through the read pipeline and response FIFO.
package imem_pkg;

    typedef enum logic [1:0] {
        F_OK       = 2'b00,
        F_MISALIGN = 2'b01,
        F_RANGE    = 2'b10
    } fault_e;

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_DRAIN = 2'b01,
        S_LOAD  = 2'b10
    } state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        fault_e      fault;
    } imem_rsp_t;

    // Misalignment is checked first so it wins over out-of-range.
    function automatic fault_e classify(input logic [31:0] addr, input logic [31:0] last_word);
        if (addr[1:0] != 2'b00) return F_MISALIGN;
        if (addr > last_word)   return F_RANGE;
        return F_OK;
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Response buffer between the read pipeline and decode. The clear input empties
// it on the next edge and takes priority over push and pop.
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr,
    input  logic      push,
    input  imem_rsp_t push_data,
    input  logic      pop,
    output logic      empty,
    output imem_rsp_t head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    imem_rsp_t     store_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (push) wp_d = (wp_q == LAST_PTR) ? '0 : wp_q + 1'b1;
        if (pop)  rp_d = (rp_q == LAST_PTR) ? '0 : rp_q + 1'b1;
        if (clr) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) store_q[wp_q] <= push_data;
    end

    assign empty = (cnt_q == '0);
    assign head  = store_q[rp_q];

endmodule

// File: rtl/imem_pipelined.sv
// Instruction memory for the fetch stage: LAT-deep read pipeline feeding an
// in-order response FIFO, outstanding-fetch limiter and a RUN/DRAIN/LOAD program FSM.
module imem_pipelined
    import imem_pkg::*;
#(
    parameter int    NUM_BYTES = 1024,
    parameter int    LAT       = 1,
    parameter int    RSP_DEPTH = 2,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_pc,
    output logic [1:0]  rsp_fault,
    input  logic        flush,
    input  logic        prog_mode,
    output logic        prog_ack,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_wdata
);
    localparam int          NUM_WORDS = NUM_BYTES / 4;
    localparam int          AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int          OW        = $clog2(RSP_DEPTH + 1);
    localparam logic [31:0] LAST_WORD = 32'(NUM_BYTES - 4);

    logic [31:0]    mem [NUM_WORDS];
    state_e         state_q, state_d;
    logic [OW-1:0]  out_q, out_d;
    logic [LAT-1:0] stg_v_q, stg_v_d;
    imem_rsp_t      stg_q [LAT];

    logic      req_acc, rsp_hs, fifo_push, fifo_empty, mem_we;
    fault_e    req_fault;
    imem_rsp_t fifo_head;

    // Gating with rst_n keeps req_ready low for the whole reset pulse.
    assign req_ready = rst_n && (state_q == S_RUN) && !prog_mode && !flush
                       && (out_q < OW'(RSP_DEPTH));
    assign req_acc   = req_valid && req_ready;
    assign req_fault = classify(req_pc, LAST_WORD);
    assign rsp_valid = !fifo_empty;
    assign rsp_hs    = rsp_valid && rsp_ready && !flush;
    assign fifo_push = stg_v_q[LAT-1] && !flush;
    assign mem_we    = (state_q == S_LOAD) && prog_we && (prog_addr <= LAST_WORD);
    assign prog_ack  = (state_q == S_LOAD);

    always_comb begin
        stg_v_d    = '0;
        stg_v_d[0] = req_acc;
        for (int i = 1; i < LAT; i++) stg_v_d[i] = stg_v_q[i-1] && !flush;
        out_d = flush ? '0 : out_q + OW'(req_acc) - OW'(rsp_hs);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (prog_mode) state_d = S_DRAIN;
            S_DRAIN: begin
                if (!prog_mode)                  state_d = S_RUN;
                else if (out_q == '0 || flush)   state_d = S_LOAD;
            end
            S_LOAD:  if (!prog_mode) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            out_q   <= '0;
            stg_v_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            stg_v_q <= stg_v_d;
        end
    end

    // Faulted requests never touch the array; their payload is forced to zero.
    always_ff @(posedge clk) begin
        if (mem_we) mem[prog_addr[AW+1:2]] <= prog_wdata;
        if (req_acc) begin
            stg_q[0].pc    <= req_pc;
            stg_q[0].fault <= req_fault;
            if (req_fault == F_OK) stg_q[0].instr <= mem[req_pc[AW+1:2]];
            else                   stg_q[0].instr <= '0;
        end
        for (int i = 1; i < LAT; i++) stg_q[i] <= stg_q[i-1];
    end

    imem_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .push      (fifo_push),
        .push_data (stg_q[LAT-1]),
        .pop       (rsp_hs),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign rsp_instr = rsp_valid ? fifo_head.instr : '0;
    assign rsp_pc    = rsp_valid ? fifo_head.pc    : '0;
    assign rsp_fault = rsp_valid ? fifo_head.fault : F_OK;

endmodule

// File: tb/tb_imem_pipelined.sv
// Bench for imem_pipelined with NUM_BYTES=1024, LAT=1, RSP_DEPTH=2.
module tb_imem_pipelined;
    localparam int NB = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_pc = '0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [31:0] rsp_instr, rsp_pc;
    logic [1:0]  rsp_fault;
    logic        flush = 1'b0, prog_mode = 1'b0, prog_ack;
    logic        prog_we = 1'b0;
    logic [31:0] prog_addr = '0, prog_wdata = '0;

    imem_pipelined #(.NUM_BYTES(NB), .LAT(1), .RSP_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_pc(rsp_pc), .rsp_fault(rsp_fault), .flush(flush),
        .prog_mode(prog_mode), .prog_ack(prog_ack), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata)
    );

    always #5 clk = ~clk;

    // Expected response = {instr, pc, fault}
    logic [65:0] exp_q[$];
    logic [31:0] ref_mem [NB/4];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  fault;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired, expected event did not occur", name);
    endtask

    function automatic logic [65:0] exp_of(input logic [31:0] pc);
        if (pc[1:0] != 2'b00) return {32'h0, pc, 2'b01};
        if (pc > 32'(NB - 4)) return {32'h0, pc, 2'b10};
        return {ref_mem[pc[9:2]], pc, 2'b00};
    endfunction

    // Scoreboard: every completed response handshake pops one expectation.
    always @(negedge clk) begin
        logic [65:0] e;
        if (rst_n) begin
            if (flush) exp_q.delete();
            else if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got pc %h expected no response", rsp_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_instr", rsp_instr, e[65:34]);
                    check("rsp_pc", rsp_pc, e[33:2]);
                    check("rsp_fault", 32'(rsp_fault), 32'(e[1:0]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [65:0] e);
        int n = 0;
        req_valid = 1'b1;
        req_pc    = pc;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (req_ready) exp_q.push_back(e);
        else fail_now("req_accept_timeout");
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            tick();
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic enter_load();
        int n = 0;
        prog_mode = 1'b1;
        @(negedge clk);
        while (!prog_ack && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!prog_ack) fail_now("prog_ack_timeout");
        tick();
    endtask

    task automatic prog_write(input logic [31:0] addr, input logic [31:0] data);
        prog_we    = 1'b1;
        prog_addr  = addr;
        prog_wdata = data;
        tick();
        prog_we = 1'b0;
        if (addr <= 32'(NB - 4)) ref_mem[addr[9:2]] = data;
    endtask

    initial begin
        logic [31:0] pc, snap_instr, snap_pc;
        int acc;

        #2;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_prog_ack", 32'(prog_ack), 32'd0);
        check("reset_rsp_instr", rsp_instr, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("run_after_reset", 32'(req_ready), 32'd1);
        tick();

        // Load the initial image through LOAD mode.
        enter_load();
        prog_write(32'h0, 32'h0000_0033);
        prog_write(32'h4, 32'h4000_0033);
        for (int i = 2; i < 16; i++) prog_write(32'(i * 4), $urandom_range(32'h7fff_ffff, 0));
        prog_write(32'(NB - 4), 32'hCAFE_F00D);
        prog_mode = 1'b0;
        tick();

        // Latency: accept in cycle 0, rsp_valid first seen in cycle 2.
        rsp_ready = 1'b1;
        issue(32'h0, exp_of(32'h0));
        @(negedge clk);
        check("lat_not_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(rsp_valid), 32'd1);
        tick();
        wait_drain("lat_drain");

        // Back-to-back fetches plus fault boundaries from a constant table.
        tbl[0] = '{32'h0,           32'h0000_0033, 2'b00};
        tbl[1] = '{32'h4,           32'h4000_0033, 2'b00};
        tbl[2] = '{32'h6,           32'h0,         2'b01};
        tbl[3] = '{32'(NB),         32'h0,         2'b10};
        tbl[4] = '{32'(NB - 4),     32'hCAFE_F00D, 2'b00};
        tbl[5] = '{32'h1,           32'h0,         2'b01};
        tbl[6] = '{32'hFFFF_FFFC,   32'h0,         2'b10};
        tbl[7] = '{32'(NB + 2),     32'h0,         2'b01};
        tbl[8] = '{32'h4,           32'h4000_0033, 2'b00};
        for (int i = 0; i < 9; i++) issue(tbl[i].pc, {tbl[i].instr, tbl[i].pc, tbl[i].fault});
        wait_drain("table_drain");

        // Backpressure: only RSP_DEPTH accepted, outputs frozen while stalled.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        pc  = 32'h10;
        acc = 0;
        snap_instr = '0;
        snap_pc    = '0;
        for (int i = 0; i < 6; i++) begin
            logic took;
            req_pc = pc;
            @(negedge clk);
            took = req_ready;
            if (took) begin
                exp_q.push_back(exp_of(pc));
                acc++;
            end
            if (i == 3) begin
                snap_instr = rsp_instr;
                snap_pc    = rsp_pc;
                check("stall_head_pc", rsp_pc, 32'h10);
            end
            tick();
            if (took) pc = pc + 32'd4;
        end
        @(negedge clk);
        check("stall_accepted", 32'(acc), 32'd2);
        check("stall_req_ready", 32'(req_ready), 32'd0);
        check("stall_valid", 32'(rsp_valid), 32'd1);
        check("stall_instr_stable", rsp_instr, snap_instr);
        check("stall_pc_stable", rsp_pc, snap_pc);
        req_valid = 1'b0;
        tick();
        rsp_ready = 1'b1;
        wait_drain("stall_drain");

        // Flush with two fetches in flight.
        issue(32'h0, exp_of(32'h0));
        issue(32'h4, exp_of(32'h4));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_no_rsp", 32'(rsp_valid), 32'd0);
        end
        tick();
        issue(32'h8, exp_of(32'h8));
        wait_drain("flush_after_fetch");

        // Drain into LOAD with two outstanding, then reprogram.
        rsp_ready = 1'b0;
        issue(32'hC, exp_of(32'hC));
        issue(32'h10, exp_of(32'h10));
        prog_mode = 1'b1;
        @(negedge clk);
        check("drain_req_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        @(negedge clk);
        check("drain_no_ack", 32'(prog_ack), 32'd0);
        tick();
        rsp_ready = 1'b1;
        enter_load();
        check("drain_delivered", 32'(exp_q.size()), 32'd0);
        prog_write(32'h8, 32'h0000_6033);
        prog_write(32'(NB), 32'hDEAD_BEEF);
        prog_mode = 1'b0;
        @(negedge clk);
        check("load_exit_not_yet", 32'(req_ready), 32'd0);
        tick();
        @(negedge clk);
        check("load_exit_ready", 32'(req_ready), 32'd1);
        tick();
        prog_we = 1'b1;
        prog_addr = 32'h4;
        prog_wdata = 32'hFFFF_FFFF;
        tick();
        prog_we = 1'b0;
        issue(32'h8, {32'h0000_6033, 32'h8, 2'b00});
        issue(32'h0, {32'h0000_0033, 32'h0, 2'b00});
        issue(32'h4, {32'h4000_0033, 32'h4, 2'b00});
        wait_drain("load_fetch_drain");

        // Asynchronous reset mid-fetch.
        rsp_ready = 1'b0;
        issue(32'h0, exp_of(32'h0));
        tick();
        check("pre_reset_valid", 32'(rsp_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_rsp_instr", rsp_instr, 32'd0);
        check("arst_rsp_pc", rsp_pc, 32'd0);
        check("arst_rsp_fault", 32'(rsp_fault), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_run", 32'(req_ready), 32'd1);
        check("arst_no_rsp", 32'(rsp_valid), 32'd0);
        tick();

        // Asynchronous reset mid-LOAD; memory contents survive.
        enter_load();
        prog_write(32'h14, 32'h1234_5678);
        #3 rst_n = 1'b0;
        #1;
        check("arst_prog_ack", 32'(prog_ack), 32'd0);
        prog_mode = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        issue(32'h8, {32'h0000_6033, 32'h8, 2'b00});
        issue(32'h14, {32'h1234_5678, 32'h14, 2'b00});
        wait_drain("retain_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
